// File: rtl/uart_command_framer_pkg.sv
// Shared types and constants for the UART command framer and the execution logic behind it.
package uart_command_framer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_WAIT_ADDR = 2'b01,
        ST_HOLD      = 2'b10
    } framer_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_TIMEOUT  = 2'b01,
        ERR_BAD_CMD  = 2'b10,
        ERR_BAD_ADDR = 2'b11
    } framer_err_t;

    // Command codes understood by the sensor/command execution logic
    localparam logic [7:0] CMD_NOP        = 8'h00;
    localparam logic [7:0] CMD_READ       = 8'h01;
    localparam logic [7:0] CMD_WRITE      = 8'h02;
    localparam logic [7:0] CMD_START      = 8'h03;
    localparam logic [7:0] CMD_STOP       = 8'h04;
    localparam logic [7:0] CMD_CALIBRATE  = 8'h05;
    localparam logic [7:0] CMD_STATUS     = 8'h06;
    localparam logic [7:0] CMD_SOFT_RESET = 8'h07;

    localparam logic [7:0] CMD_MAX_DEFAULT  = 8'h07;
    localparam logic [7:0] ADDR_MAX_DEFAULT = 8'd31;

endpackage

// File: rtl/uart_command_framer_timeout_counter.sv
// Inter-byte timeout counter: counts enabled cycles and pulses when the terminal count is hit.
module framer_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;
    logic          w_terminal;

    assign w_terminal = i_enable && (r_count == TC_VAL);
    assign o_terminal = w_terminal;

    // Count enabled cycles; wrap to zero on terminal so the width never overflows
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (w_terminal) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CW'(1);
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/uart_command_framer.sv
// Assembles command/address byte pairs from the UART receiver, validates them and
// hands valid frames downstream over valid/ready; reports framing errors and overruns.
module uart_command_framer
    import uart_command_framer_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0] CMD_MAX        = CMD_MAX_DEFAULT,
    parameter logic [7:0] ADDR_MAX       = ADDR_MAX_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_byte_valid,
    input  logic [7:0] rx_byte,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [7:0] cmd_code,
    output logic [7:0] cmd_addr,
    output logic       busy,
    output logic       frame_error,
    output logic [1:0] error_code,
    output logic       overrun,
    input  logic       clear_status
);

    framer_state_t r_state;
    framer_state_t w_state_next;
    framer_err_t   w_err_code;
    logic [7:0]    r_cmd_byte;
    logic [7:0]    w_cmd_byte_next;
    logic          w_load_frame;
    logic          w_handshake;
    logic          w_err_event;
    logic          w_overrun_event;
    logic          w_tmo_clear;
    logic          w_tmo_enable;
    logic          w_tmo_terminal;

    assign w_tmo_enable = (r_state == ST_WAIT_ADDR) && !rx_byte_valid;
    assign w_tmo_clear  = !w_tmo_enable;

    framer_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock     (clock),
        .reset     (reset),
        .i_clear   (w_tmo_clear),
        .i_enable  (w_tmo_enable),
        .o_terminal(w_tmo_terminal)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and per-cycle events; a byte arriving on the timeout cycle wins
    always_comb begin
        w_state_next    = r_state;
        w_cmd_byte_next = r_cmd_byte;
        w_load_frame    = 1'b0;
        w_handshake     = 1'b0;
        w_err_event     = 1'b0;
        w_err_code      = ERR_NONE;
        w_overrun_event = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rx_byte_valid) begin
                    w_cmd_byte_next = rx_byte;
                    w_state_next    = ST_WAIT_ADDR;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WAIT_ADDR: begin
                if (rx_byte_valid) begin
                    if (r_cmd_byte > CMD_MAX) begin
                        w_err_event  = 1'b1;
                        w_err_code   = ERR_BAD_CMD;
                        w_state_next = ST_IDLE;
                    end else if (rx_byte > ADDR_MAX) begin
                        w_err_event  = 1'b1;
                        w_err_code   = ERR_BAD_ADDR;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_load_frame = 1'b1;
                        w_state_next = ST_HOLD;
                    end
                end else if (w_tmo_terminal) begin
                    w_err_event  = 1'b1;
                    w_err_code   = ERR_TIMEOUT;
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_WAIT_ADDR;
                end
            end
            ST_HOLD: begin
                if (cmd_ready) begin
                    w_handshake = 1'b1;
                    if (rx_byte_valid) begin
                        w_cmd_byte_next = rx_byte;
                        w_state_next    = ST_WAIT_ADDR;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else if (rx_byte_valid) begin
                    w_overrun_event = 1'b1;
                end else begin
                    w_state_next = ST_HOLD;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Frame datapath and registered status outputs; new events beat clear_status
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cmd_byte  <= 8'h00;
            cmd_valid   <= 1'b0;
            cmd_code    <= 8'h00;
            cmd_addr    <= 8'h00;
            busy        <= 1'b0;
            frame_error <= 1'b0;
            error_code  <= ERR_NONE;
            overrun     <= 1'b0;
        end else begin
            r_cmd_byte  <= w_cmd_byte_next;
            busy        <= (w_state_next != ST_IDLE);
            frame_error <= w_err_event;
            if (w_load_frame) begin
                cmd_valid <= 1'b1;
                cmd_code  <= r_cmd_byte;
                cmd_addr  <= rx_byte;
            end else if (w_handshake) begin
                cmd_valid <= 1'b0;
            end else begin
                cmd_valid <= cmd_valid;
            end
            if (w_err_event) begin
                error_code <= w_err_code;
            end else if (clear_status) begin
                error_code <= ERR_NONE;
            end else begin
                error_code <= error_code;
            end
            if (w_overrun_event) begin
                overrun <= 1'b1;
            end else if (clear_status) begin
                overrun <= 1'b0;
            end else begin
                overrun <= overrun;
            end
        end
    end

endmodule

// File: tb/tb_uart_command_framer.sv
// Directed bench for uart_command_framer with a short timeout; outputs sampled on falling edges.
module tb_uart_command_framer;

    logic       clock;
    logic       reset;
    logic       rx_byte_valid;
    logic [7:0] rx_byte;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_code;
    logic [7:0] cmd_addr;
    logic       busy;
    logic       frame_error;
    logic [1:0] error_code;
    logic       overrun;
    logic       clear_status;

    int vectors;
    int miscompares;

    uart_command_framer #(
        .TIMEOUT_CYCLES(100),
        .CMD_MAX       (8'h07),
        .ADDR_MAX      (8'd31)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rx_byte_valid(rx_byte_valid),
        .rx_byte      (rx_byte),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_code     (cmd_code),
        .cmd_addr     (cmd_addr),
        .busy         (busy),
        .frame_error  (frame_error),
        .error_code   (error_code),
        .overrun      (overrun),
        .clear_status (clear_status)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic strobe(input logic [7:0] b);
        rx_byte       = b;
        rx_byte_valid = 1'b1;
        @(negedge clock);
        rx_byte_valid = 1'b0;
        rx_byte       = 8'hA5;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic handshake();
        cmd_ready = 1'b1;
        @(negedge clock);
        cmd_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        vectors++;
        if ({cmd_valid, cmd_code, cmd_addr, busy, frame_error, error_code, overrun} !== 21'd0) begin
            miscompares++;
            $display("FAIL reset_state: got valid=%b code=%h addr=%h busy=%b ferr=%b ecode=%b ovr=%b want all zero",
                     cmd_valid, cmd_code, cmd_addr, busy, frame_error, error_code, overrun);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_basic_frame();
        strobe(8'h03);
        idle(40);
        vectors++;
        if (cmd_valid !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_wait: got valid=%b busy=%b want valid=0 busy=1", cmd_valid, busy);
        end
        strobe(8'h05);
        vectors++;
        if (cmd_valid !== 1'b1 || cmd_code !== 8'h03 || cmd_addr !== 8'h05 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_frame: got valid=%b code=%h addr=%h busy=%b want 1/03/05/1",
                     cmd_valid, cmd_code, cmd_addr, busy);
        end
        idle(3);
        vectors++;
        if (cmd_valid !== 1'b1 || cmd_code !== 8'h03 || cmd_addr !== 8'h05) begin
            miscompares++;
            $display("FAIL basic_hold: got valid=%b code=%h addr=%h want 1/03/05", cmd_valid, cmd_code, cmd_addr);
        end
        handshake();
        vectors++;
        if (cmd_valid !== 1'b0 || busy !== 1'b0 || frame_error !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_accept: got valid=%b busy=%b ferr=%b want 0/0/0", cmd_valid, busy, frame_error);
        end
    endtask

    task automatic test_timeout();
        strobe(8'h01);
        idle(99);
        vectors++;
        if (frame_error !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_early: got ferr=%b busy=%b want 0/1", frame_error, busy);
        end
        idle(1);
        vectors++;
        if (frame_error !== 1'b1 || error_code !== 2'b01 || busy !== 1'b0 || cmd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_pulse: got ferr=%b ecode=%b busy=%b valid=%b want 1/01/0/0",
                     frame_error, error_code, busy, cmd_valid);
        end
        idle(1);
        vectors++;
        if (frame_error !== 1'b0 || error_code !== 2'b01) begin
            miscompares++;
            $display("FAIL timeout_hold: got ferr=%b ecode=%b want 0/01", frame_error, error_code);
        end
        strobe(8'h02);
        strobe(8'h04);
        vectors++;
        if (cmd_valid !== 1'b1 || cmd_code !== 8'h02 || cmd_addr !== 8'h04) begin
            miscompares++;
            $display("FAIL timeout_recover: got valid=%b code=%h addr=%h want 1/02/04", cmd_valid, cmd_code, cmd_addr);
        end
        handshake();
    endtask

    task automatic test_bad_frames();
        strobe(8'h09);
        strobe(8'h02);
        vectors++;
        if (frame_error !== 1'b1 || error_code !== 2'b10 || cmd_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_cmd: got ferr=%b ecode=%b valid=%b busy=%b want 1/10/0/0",
                     frame_error, error_code, cmd_valid, busy);
        end
        idle(1);
        vectors++;
        if (frame_error !== 1'b0 || error_code !== 2'b10) begin
            miscompares++;
            $display("FAIL bad_cmd_hold: got ferr=%b ecode=%b want 0/10", frame_error, error_code);
        end
        strobe(8'h02);
        strobe(8'd40);
        vectors++;
        if (frame_error !== 1'b1 || error_code !== 2'b11 || cmd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_addr: got ferr=%b ecode=%b valid=%b want 1/11/0", frame_error, error_code, cmd_valid);
        end
        strobe(8'h0A);
        strobe(8'd40);
        vectors++;
        if (frame_error !== 1'b1 || error_code !== 2'b10 || cmd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL cmd_priority: got ferr=%b ecode=%b valid=%b want 1/10/0", frame_error, error_code, cmd_valid);
        end
        idle(1);
    endtask

    task automatic test_overrun();
        strobe(8'h01);
        strobe(8'h01);
        strobe(8'h07);
        vectors++;
        if (overrun !== 1'b1 || cmd_valid !== 1'b1 || cmd_code !== 8'h01 || cmd_addr !== 8'h01 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_set: got ovr=%b valid=%b code=%h addr=%h busy=%b want 1/1/01/01/1",
                     overrun, cmd_valid, cmd_code, cmd_addr, busy);
        end
        clear_status = 1'b1;
        @(negedge clock);
        clear_status = 1'b0;
        vectors++;
        if (overrun !== 1'b0 || error_code !== 2'b00 || cmd_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_status: got ovr=%b ecode=%b valid=%b want 0/00/1", overrun, error_code, cmd_valid);
        end
        cmd_ready = 1'b1;
        strobe(8'h07);
        cmd_ready = 1'b0;
        vectors++;
        if (cmd_valid !== 1'b0 || busy !== 1'b1 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_and_byte: got valid=%b busy=%b ovr=%b want 0/1/0", cmd_valid, busy, overrun);
        end
        strobe(8'h03);
        vectors++;
        if (cmd_valid !== 1'b1 || cmd_code !== 8'h07 || cmd_addr !== 8'h03) begin
            miscompares++;
            $display("FAIL carried_byte: got valid=%b code=%h addr=%h want 1/07/03", cmd_valid, cmd_code, cmd_addr);
        end
        handshake();
    endtask

    task automatic test_timeout_edges();
        strobe(8'h06);
        idle(99);
        strobe(8'h10);
        vectors++;
        if (frame_error !== 1'b0 || cmd_valid !== 1'b1 || cmd_code !== 8'h06 || cmd_addr !== 8'h10) begin
            miscompares++;
            $display("FAIL byte_on_timeout: got ferr=%b valid=%b code=%h addr=%h want 0/1/06/10",
                     frame_error, cmd_valid, cmd_code, cmd_addr);
        end
        handshake();
        strobe(8'h09);
        strobe(8'h00);
        strobe(8'h02);
        idle(99);
        clear_status = 1'b1;
        @(negedge clock);
        clear_status = 1'b0;
        vectors++;
        if (frame_error !== 1'b1 || error_code !== 2'b01) begin
            miscompares++;
            $display("FAIL clear_vs_timeout: got ferr=%b ecode=%b want 1/01", frame_error, error_code);
        end
        idle(1);
    endtask

    task automatic test_midframe_reset();
        strobe(8'h02);
        reset = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b0 || error_code !== 2'b00 || frame_error !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_wait_addr: got busy=%b ecode=%b ferr=%b want 0/00/0", busy, error_code, frame_error);
        end
        @(negedge clock);
        reset = 1'b0;
        strobe(8'h03);
        strobe(8'h04);
        reset = 1'b1;
        #1;
        vectors++;
        if (cmd_valid !== 1'b0 || cmd_code !== 8'h00 || cmd_addr !== 8'h00 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: got valid=%b code=%h addr=%h busy=%b want 0/00/00/0",
                     cmd_valid, cmd_code, cmd_addr, busy);
        end
        @(negedge clock);
        reset = 1'b0;
        strobe(8'h00);
        strobe(8'h1F);
        vectors++;
        if (cmd_valid !== 1'b1 || cmd_code !== 8'h00 || cmd_addr !== 8'h1F || frame_error !== 1'b0) begin
            miscompares++;
            $display("FAIL addr_max_frame: got valid=%b code=%h addr=%h ferr=%b want 1/00/1F/0",
                     cmd_valid, cmd_code, cmd_addr, frame_error);
        end
        handshake();
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b0;
        rx_byte_valid = 1'b0;
        rx_byte       = 8'h00;
        cmd_ready     = 1'b0;
        clear_status  = 1'b0;
        test_reset();
        test_basic_frame();
        test_timeout();
        test_bad_frames();
        test_overrun();
        test_timeout_edges();
        test_midframe_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
